cache_ctrl_dm: RTL and testbench
================================

# cache_ctrl_dm

Parametrised direct-mapped read cache controller between the core's load/fetch port and the line-wide memory port. It owns tag, valid and data storage and performs its own tag compare. It refills whole lines over a request/acknowledge handshake, supports whole-cache invalidate, and keeps saturating hit/miss counters. Line count and line width are set by parameters.

## Interface
- ADDR_W, 32: byte address width.
- WORD_W, 32: data word width.
- LINES, 4: number of lines; power of two, at least 2.
- WORDS, 4: words per line; power of two, at least 2.
- CNT_W, 16: width of each performance counter.
- Derived widths:
  - OFF_W = log2(WORDS)
  - IDX_W = log2(LINES)
  - TAG_W = ADDR_W - IDX_W - OFF_W - 2
- Address split: addr[1:0] is ignored; word = addr[OFF_W+1:2]; index = next IDX_W bits; tag = remaining upper bits.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cpu_req_i  in  1  read request.
- cpu_addr_i  in  ADDR_W  request byte address.
- cpu_ready_o  out  1  controller can accept a request this cycle.
- cpu_rvalid_o  out  1  one-cycle pulse; cpu_rdata_o is valid.
- cpu_rdata_o  out  WORD_W  read data.
- inv_i  in  1  invalidate all lines.
- mem_req_o  out  1  line refill request.
- mem_addr_o  out  ADDR_W  line-aligned refill address (low OFF_W+2 bits zero).
- mem_ack_i  in  1  refill data present this cycle.
- mem_data_i  in  WORD_W*WORDS  full line; word 0 in the LSBs.
- hit_cnt_o  out  CNT_W  saturating hit count.
- miss_cnt_o  out  CNT_W  saturating miss count.
- busy_o  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, LOOKUP, REFILL, INVAL.
- cpu_ready_o = (state == IDLE) && !inv_i && !inv_pend. This is the only combinational input-to-output path.
- IDLE:
  - Invalidate wins: if inv_i or inv_pend is high, go to INVAL.
  - Otherwise, if cpu_req_i && cpu_ready_o, register the address and go to LOOKUP.
- LOOKUP: hit = valid[idx] && tag_array[idx] == tag.
  - Hit: register the selected word into cpu_rdata_o, pulse cpu_rvalid_o, increment hit_cnt, go to IDLE.
  - Miss: increment miss_cnt, set mem_req_o = 1 and mem_addr_o = {tag, idx, zeros}, go to REFILL.
- REFILL:
  - mem_req_o and mem_addr_o stay stable until mem_ack_i is sampled high.
  - On ack: write mem_data_i into data[idx], tag into tag_array[idx], set valid[idx] = 1.
  - Also on ack: cpu_rdata_o = word `word` of mem_data_i, pulse cpu_rvalid_o, drop mem_req_o, go to IDLE.
- INVAL: clear all valid bits in one cycle, clear inv_pend, go to IDLE. Tag and data contents are untouched.
- inv_i sampled high while in LOOKUP or REFILL sets inv_pend. The pending invalidate runs only after the current request has returned its data.
- mem_ack_i is ignored outside REFILL.
- Counters increment by 1 and hold at all-ones. Only reset clears them.

## Timing
- Reset values:
  - state = IDLE; all valid bits = 0; inv_pend = 0.
  - cpu_rvalid_o, cpu_rdata_o, mem_req_o, mem_addr_o, hit_cnt_o, miss_cnt_o, busy_o = 0.
  - Tag and data arrays are not reset, so they can infer RAM.
- Hit latency: request accepted at edge N; rvalid is high in cycle N+2.
- The cycle in which rvalid is high is an IDLE cycle, so a new request may be accepted then. Peak throughput is one hit every 2 cycles.
- Miss: mem_req_o rises in cycle N+2. If mem_ack_i is first high in cycle M, rvalid is high in M+1 and mem_req_o is low in M+1.
- mem_ack_i in the very first REFILL cycle is legal; minimum miss latency is 3 cycles.
- A request and inv_i arriving in the same IDLE cycle: invalidate is taken and the request is not accepted, because ready is low.
- Reset during REFILL:
  - The next cycle is IDLE with mem_req_o = 0 and no rvalid.
  - A late mem_ack_i is ignored.
  - All lines are invalid afterwards.

## Test plan
Defaults: LINES=4, WORDS=4, ADDR_W=32.
- Cold miss:
  - Stimulus: after reset, request 0x104; mem_ack_i 3 cycles after mem_req_o rises, mem_data_i = {D3,D2,D1,D0}.
  - Response: mem_req_o rises with mem_addr_o = 0x100; rvalid with D1 one cycle after the ack; miss_cnt_o = 1.
- Hit:
  - Stimulus: request 0x10C.
  - Response: rvalid 2 cycles after accept with D3; mem_req_o stays 0; hit_cnt_o = 1.
- Conflict:
  - Stimulus: request 0x504 (same index, tag 0x14), then 0x104.
  - Response: both miss; miss_cnt_o = 3.
- Invalidate:
  - Stimulus: pulse inv_i in IDLE, then request 0x504.
  - Response: cpu_ready_o low for 2 cycles; the request misses.
- Invalidate and reset during refill:
  - Stimulus: assert inv_i during REFILL.
  - Response: the current request completes, then INVAL runs, and the next access misses.
  - Stimulus: assert reset_n low during REFILL, then send a late ack.
  - Response: no rvalid, mem_req_o = 0, counters = 0.
- Counter saturation:
  - Stimulus: CNT_W=2, five hits to one cached line.
  - Response: hit_cnt_o = 3 and holds.

Source files
------------

// File: rtl/cache_ctrl_dm.sv
// ---------------------------------------------------------------------------
// cache_ctrl_dm
// Direct-mapped read cache controller sitting between the core's load/fetch
// port and a line-wide memory port. Holds its own tag, valid and data
// storage, refills whole lines over a req/ack handshake, supports a
// whole-cache invalidate and keeps saturating hit/miss counters.
//
// Ports:
//   clk, reset_n               clock, synchronous active-low reset
//   cpu_req_i, cpu_addr_i      read request and its byte address
//   cpu_ready_o                request can be accepted this cycle
//   cpu_rvalid_o, cpu_rdata_o  one-cycle read-data pulse and data
//   inv_i                      invalidate all lines
//   mem_req_o, mem_addr_o      line refill request, line-aligned address
//   mem_ack_i, mem_data_i      refill line present (word 0 in LSBs)
//   hit_cnt_o, miss_cnt_o      saturating performance counters
//   busy_o                     controller is not in IDLE
// ---------------------------------------------------------------------------
module cache_ctrl_dm #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32,
   parameter int LINES  = 4,
   parameter int WORDS  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cpu_req_i,
   input  logic [ADDR_W-1:0]       cpu_addr_i,
   output logic                    cpu_ready_o,
   output logic                    cpu_rvalid_o,
   output logic [WORD_W-1:0]       cpu_rdata_o,
   input  logic                    inv_i,
   output logic                    mem_req_o,
   output logic [ADDR_W-1:0]       mem_addr_o,
   input  logic                    mem_ack_i,
   input  logic [WORD_W*WORDS-1:0] mem_data_i,
   output logic [CNT_W-1:0]        hit_cnt_o,
   output logic [CNT_W-1:0]        miss_cnt_o,
   output logic                    busy_o
);

   localparam int OFF_W  = $clog2(WORDS);
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W - 2;
   localparam int LINE_W = WORD_W * WORDS;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      REFILL,
      INVAL
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   addr_q;
   logic                inv_pend;
   logic [LINES-1:0]    valid;

   logic [TAG_W-1:0]    tag_array  [LINES];
   logic [LINE_W-1:0]   data_array [LINES];

   logic [TAG_W-1:0]    req_tag;
   logic [IDX_W-1:0]    req_idx;
   logic [OFF_W-1:0]    req_word;
   logic                lookup_hit;
   logic [WORD_W-1:0]   hit_word;
   logic [WORD_W-1:0]   fill_word;
   logic                fill_en;

   // Fields of the registered request address.
   assign req_tag  = addr_q[ADDR_W-1 -: TAG_W];
   assign req_idx  = addr_q[OFF_W+2 +: IDX_W];
   assign req_word = addr_q[2 +: OFF_W];

   assign lookup_hit = valid[req_idx] && (tag_array[req_idx] == req_tag);

   // Fill writes are suppressed while reset is asserted so an ack racing a
   // reset cannot leave a half-updated line behind.
   assign fill_en = reset_n && (state == REFILL) && mem_ack_i;

   // Word select from the stored line (hit path) and the incoming line
   // (refill path).
   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      hit_word  = '0;
      fill_word = '0;
      for (int w = 0; w < WORDS; w++) begin
         if (OFF_W'(w) == req_word) begin
            hit_word  = data_array[req_idx][w*WORD_W +: WORD_W];
            fill_word = mem_data_i[w*WORD_W +: WORD_W];
         end
      end
   end

   assign cpu_ready_o = (state == IDLE) && !inv_i && !inv_pend;
   assign busy_o      = (state != IDLE);

   // Tag and data storage.
   // NOTE: no reset here on purpose; the valid bits alone define line
   // validity, and an unreset array can map onto RAM.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_array[req_idx]  <= req_tag;
         data_array[req_idx] <= mem_data_i;
      end
   end

   // Control FSM with registered outputs.
   // NOTE: state is updated with non-blocking assignments so every register
   // sees the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         addr_q       <= '0;
         inv_pend     <= 1'b0;
         valid        <= '0;
         cpu_rvalid_o <= 1'b0;
         cpu_rdata_o  <= '0;
         mem_req_o    <= 1'b0;
         mem_addr_o   <= '0;
         hit_cnt_o    <= '0;
         miss_cnt_o   <= '0;
      end else begin
         cpu_rvalid_o <= 1'b0;

         // An invalidate arriving mid-request is deferred until the data
         // has been returned.
         if (((state == LOOKUP) || (state == REFILL)) && inv_i)
            inv_pend <= 1'b1;

         case (state)
            IDLE: begin
               if (inv_i || inv_pend) begin
                  state <= INVAL;
               end else if (cpu_req_i) begin
                  addr_q <= cpu_addr_i;
                  state  <= LOOKUP;
               end
            end

            LOOKUP: begin
               if (lookup_hit) begin
                  cpu_rdata_o  <= hit_word;
                  cpu_rvalid_o <= 1'b1;
                  if (hit_cnt_o != '1)
                     hit_cnt_o <= hit_cnt_o + CNT_W'(1);
                  state <= IDLE;
               end else begin
                  if (miss_cnt_o != '1)
                     miss_cnt_o <= miss_cnt_o + CNT_W'(1);
                  mem_req_o  <= 1'b1;
                  mem_addr_o <= {req_tag, req_idx, {(OFF_W+2){1'b0}}};
                  state      <= REFILL;
               end
            end

            REFILL: begin
               if (mem_ack_i) begin
                  valid[req_idx] <= 1'b1;
                  cpu_rdata_o    <= fill_word;
                  cpu_rvalid_o   <= 1'b1;
                  mem_req_o      <= 1'b0;
                  state          <= IDLE;
               end
            end

            INVAL: begin
               valid    <= '0;
               inv_pend <= 1'b0;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl_dm
// Self-checking bench for cache_ctrl_dm. A second instance with CNT_W=2
// shares every input so counter saturation is observed on the same traffic.
// Memory contents are a fixed function of the address: word w of the line
// at address A is 32'hA500_0000 | A | w.
// ---------------------------------------------------------------------------
module tb_cache_ctrl_dm;

   localparam int ADDR_W = 32;
   localparam int WORD_W = 32;
   localparam int WORDS  = 4;
   localparam int LINE_W = WORD_W * WORDS;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               cpu_req = 1'b0;
   logic [ADDR_W-1:0]  cpu_addr = '0;
   logic               inv_i = 1'b0;
   logic               mem_ack = 1'b0;
   logic [LINE_W-1:0]  mem_data = '0;

   logic               cpu_ready, cpu_rvalid, mem_req, busy;
   logic [WORD_W-1:0]  cpu_rdata;
   logic [ADDR_W-1:0]  mem_addr;
   logic [15:0]        hit_cnt, miss_cnt;

   logic               s_ready, s_rvalid, s_mem_req, s_busy;
   logic [WORD_W-1:0]  s_rdata;
   logic [ADDR_W-1:0]  s_mem_addr;
   logic [1:0]         s_hit_cnt, s_miss_cnt;

   int tests  = 0;
   int failed = 0;
   int exp_hit  = 0;
   int exp_miss = 0;

   always #5 clk = ~clk;

   cache_ctrl_dm #(.CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr), .cpu_ready_o(cpu_ready),
      .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata), .inv_i(inv_i),
      .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack),
      .mem_data_i(mem_data), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt),
      .busy_o(busy)
   );

   cache_ctrl_dm #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset_n(reset_n),
      .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr), .cpu_ready_o(s_ready),
      .cpu_rvalid_o(s_rvalid), .cpu_rdata_o(s_rdata), .inv_i(inv_i),
      .mem_req_o(s_mem_req), .mem_addr_o(s_mem_addr), .mem_ack_i(mem_ack),
      .mem_data_i(mem_data), .hit_cnt_o(s_hit_cnt), .miss_cnt_o(s_miss_cnt),
      .busy_o(s_busy)
   );

   typedef struct {
      logic [31:0] addr;
      bit          hit;
      int          ack_dly;
   } vec_t;

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return 32'hA500_0000 | {a[31:4], 4'h0} | {30'd0, a[3:2]};
   endfunction

   function automatic logic [LINE_W-1:0] line_of(input logic [31:0] a);
      logic [LINE_W-1:0] l;
      for (int w = 0; w < WORDS; w++)
         l[w*WORD_W +: WORD_W] = 32'hA500_0000 | {a[31:4], 4'h0} | w;
      return l;
   endfunction

   function automatic logic [1:0] sat2(input int v);
      return (v > 3) ? 2'd3 : v[1:0];
   endfunction

   task automatic check_counters();
      check("hit_cnt",      hit_cnt,    exp_hit);
      check("miss_cnt",     miss_cnt,   exp_miss);
      check("sat_hit_cnt",  s_hit_cnt,  sat2(exp_hit));
      check("sat_miss_cnt", s_miss_cnt, sat2(exp_miss));
   endtask

   // One read transaction. inv_mid pulses inv_i in the first REFILL cycle
   // (needs ack_dly >= 1) and then checks the deferred invalidate.
   task automatic do_read(input logic [31:0] addr, input bit hit,
                          input int ack_dly, input bit inv_mid);
      int n = 0;
      while (!cpu_ready && n < 20) begin
         tick();
         n++;
      end
      check("ready_before_req", cpu_ready, 1'b1);
      cpu_req  = 1'b1;
      cpu_addr = addr;
      tick();
      cpu_req  = 1'b0;
      // LOOKUP cycle
      check("lookup_busy",   busy,       1'b1);
      check("lookup_ready",  cpu_ready,  1'b0);
      check("lookup_rvalid", cpu_rvalid, 1'b0);
      check("lookup_memreq", mem_req,    1'b0);
      tick();
      if (hit) begin
         exp_hit++;
         check("hit_rvalid", cpu_rvalid, 1'b1);
         check("hit_rdata",  cpu_rdata,  word_of(addr));
         check("hit_memreq", mem_req,    1'b0);
      end else begin
         exp_miss++;
         check("miss_memreq",  mem_req,    1'b1);
         check("miss_memaddr", mem_addr,   {addr[31:4], 4'h0});
         check("miss_rvalid",  cpu_rvalid, 1'b0);
         for (int k = 0; k < ack_dly; k++) begin
            if (inv_mid && k == 0) inv_i = 1'b1;
            tick();
            inv_i = 1'b0;
            check("refill_memreq_hold", mem_req, 1'b1);
            check("refill_rvalid",      cpu_rvalid, 1'b0);
         end
         mem_ack  = 1'b1;
         mem_data = line_of(addr);
         tick();
         mem_ack  = 1'b0;
         mem_data = {4{32'hDEAD_BEEF}};
         check("fill_rvalid", cpu_rvalid, 1'b1);
         check("fill_rdata",  cpu_rdata,  word_of(addr));
         check("fill_memreq", mem_req,    1'b0);
      end
      check_counters();
      if (inv_mid) check("pend_ready_low", cpu_ready, 1'b0);
      tick();
      check("rvalid_pulse", cpu_rvalid, 1'b0);
      if (inv_mid) begin
         check("pend_inval_busy", busy, 1'b1);
         tick();
         check("pend_idle_busy",  busy,      1'b0);
         check("pend_idle_ready", cpu_ready, 1'b1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs [8];
      vecs[0] = '{32'h0000_0104, 1'b0, 3};  // cold miss, D1
      vecs[1] = '{32'h0000_010C, 1'b1, 0};  // hit, D3
      vecs[2] = '{32'h0000_0504, 1'b0, 0};  // conflict, ack in first REFILL cycle
      vecs[3] = '{32'h0000_0104, 1'b0, 1};  // conflict back
      vecs[4] = '{32'h0000_0108, 1'b1, 0};
      vecs[5] = '{32'h0000_0010, 1'b0, 2};  // index 1
      vecs[6] = '{32'h0000_001C, 1'b1, 0};
      vecs[7] = '{32'h0000_0100, 1'b1, 0};  // index 0 untouched by index 1 fill

      // Reset state
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check("rst_ready",   cpu_ready,  1'b1);
      check("rst_rvalid",  cpu_rvalid, 1'b0);
      check("rst_rdata",   cpu_rdata,  32'h0);
      check("rst_memreq",  mem_req,    1'b0);
      check("rst_memaddr", mem_addr,   32'h0);
      check("rst_busy",    busy,       1'b0);
      check_counters();

      for (int i = 0; i < 8; i++)
         do_read(vecs[i].addr, vecs[i].hit, vecs[i].ack_dly, 1'b0);
      check("conflict_miss_cnt", miss_cnt, 16'd4);

      // Invalidate pulse in IDLE: ready low for two cycles, then a miss.
      inv_i = 1'b1;
      #1;
      check("inv_ready_comb", cpu_ready, 1'b0);
      tick();
      inv_i = 1'b0;
      check("inv_state_busy", busy,      1'b1);
      check("inv_state_ready", cpu_ready, 1'b0);
      tick();
      check("inv_done_ready", cpu_ready, 1'b1);
      do_read(32'h0000_0504, 1'b0, 1, 1'b0);

      // Invalidate during refill: request completes, then INVAL, then miss.
      do_read(32'h0000_0010, 1'b0, 2, 1'b1);
      do_read(32'h0000_0014, 1'b0, 1, 1'b0);

      // Request and invalidate in the same IDLE cycle: invalidate wins.
      cpu_req  = 1'b1;
      cpu_addr = 32'h0000_0014;
      inv_i    = 1'b1;
      #1;
      check("same_cycle_ready", cpu_ready, 1'b0);
      tick();
      cpu_req = 1'b0;
      inv_i   = 1'b0;
      check("same_cycle_inval", busy,    1'b1);
      check("same_cycle_memreq", mem_req, 1'b0);
      tick();
      check("same_cycle_idle",   busy,       1'b0);
      check("same_cycle_rvalid", cpu_rvalid, 1'b0);
      tick();
      check("same_cycle_dropped", busy, 1'b0);
      check_counters();

      // Reset during REFILL, then a late ack.
      cpu_req  = 1'b1;
      cpu_addr = 32'h0000_0020;
      tick();
      cpu_req = 1'b0;
      tick();
      check("rr_memreq_up", mem_req, 1'b1);
      reset_n = 1'b0;
      tick();
      reset_n  = 1'b1;
      exp_hit  = 0;
      exp_miss = 0;
      check("rr_memreq", mem_req,    1'b0);
      check("rr_rvalid", cpu_rvalid, 1'b0);
      check("rr_busy",   busy,       1'b0);
      check_counters();
      mem_ack  = 1'b1;
      mem_data = line_of(32'h0000_0020);
      tick();
      mem_ack = 1'b0;
      check("late_ack_rvalid", cpu_rvalid, 1'b0);
      check("late_ack_memreq", mem_req,    1'b0);
      check("late_ack_busy",   busy,       1'b0);
      tick();
      check("late_ack_rvalid2", cpu_rvalid, 1'b0);
      do_read(32'h0000_0100, 1'b0, 1, 1'b0);
      do_read(32'h0000_0020, 1'b0, 0, 1'b0);

      // Saturation: five hits on one line; the CNT_W=2 copy holds at 3.
      for (int i = 0; i < 5; i++)
         do_read(32'h0000_0104, 1'b1, 0, 1'b0);
      check("sat_hold", s_hit_cnt, 2'd3);
      check("wide_hits", hit_cnt, 16'd5);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
